// File: rtl/hamming16_enc_if.sv
// Handshake bundle for the Hamming(21,16) encoder: input word with injection
// sideband on one side, codeword with injection flag on the other.
interface hamming16_enc_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        inj_en;
    logic [4:0]  inj_pos;
    logic        out_valid;
    logic        out_ready;
    logic [20:0] out_code;
    logic        out_inj;

    // Valid/ready: a beat transfers on a rising edge where valid & ready are
    // both high; a producer holds its payload stable until that edge.
    modport master (
        output in_valid, in_data, inj_en, inj_pos, out_ready,
        input  in_ready, out_valid, out_code, out_inj
    );

    modport slave (
        input  in_valid, in_data, inj_en, inj_pos, out_ready,
        output in_ready, out_valid, out_code, out_inj
    );
endinterface

// File: rtl/hamming16_enc.sv
// Two-stage elastic Hamming(21,16) encoder with per-word single-bit error
// injection and a wrapping count of delivered codewords.
module hamming16_enc #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    hamming16_enc_if.slave   bus,
    output logic [CNT_W-1:0] word_cnt
);

    logic        s1_valid;
    logic [15:0] s1_data;
    logic        s1_inj_en;
    logic [4:0]  s1_inj_pos;

    logic        s2_valid;
    logic [20:0] s2_code;
    logic        s2_inj;

    logic        s1_load;
    logic        s2_load;
    logic [20:0] placed;
    logic [20:0] enc_code;
    logic        inj_hit;

    assign s2_load     = s1_valid & (~s2_valid | bus.out_ready);
    assign bus.in_ready = ~s1_valid | ~s2_valid | bus.out_ready;
    assign s1_load     = bus.in_valid & bus.in_ready;

    assign bus.out_valid = s2_valid;
    assign bus.out_code  = s2_code;
    assign bus.out_inj   = s2_inj;

    // Parity k covers every index whose position (index+1) has bit k set;
    // parity slots are still zero in 'placed', so they do not disturb the XOR.
    always_comb begin
        placed        = '0;
        placed[2]     = s1_data[0];
        placed[6:4]   = s1_data[3:1];
        placed[14:8]  = s1_data[10:4];
        placed[20:16] = s1_data[15:11];

        enc_code     = placed;
        enc_code[0]  = ^(placed & 21'h155555);
        enc_code[1]  = ^(placed & 21'h066666);
        enc_code[3]  = ^(placed & 21'h187878);
        enc_code[7]  = ^(placed & 21'h007F80);
        enc_code[15] = ^(placed & 21'h1F8000);

        inj_hit = s1_inj_en && (s1_inj_pos <= 5'd20);
        if (inj_hit) begin
            enc_code = enc_code ^ (21'd1 << s1_inj_pos);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            s1_inj_en  <= 1'b0;
            s1_inj_pos <= '0;
            s2_valid   <= 1'b0;
            s2_code    <= '0;
            s2_inj     <= 1'b0;
            word_cnt   <= '0;
        end else begin
            if (s1_load) begin
                s1_data    <= bus.in_data;
                s1_inj_en  <= bus.inj_en;
                s1_inj_pos <= bus.inj_pos;
            end

            if (s1_load) begin
                s1_valid <= 1'b1;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                s2_code <= enc_code;
                s2_inj  <= inj_hit;
            end

            if (s2_load) begin
                s2_valid <= 1'b1;
            end else if (bus.out_ready) begin
                s2_valid <= 1'b0;
            end

            if (s2_valid && bus.out_ready) begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hamming16_enc.sv
// Bench for hamming16_enc: directed streams, injection, backpressure, random
// round-trip through a behavioural decoder, mid-stream reset and counter wrap.
module tb_hamming16_enc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] word_cnt;
    logic [3:0]  word_cnt4;

    hamming16_enc_if bus ();
    hamming16_enc_if bus4 ();

    hamming16_enc #(.CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .word_cnt (word_cnt)
    );

    hamming16_enc #(.CNT_W(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus4),
        .word_cnt (word_cnt4)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;
    int cyc = 0;
    int h4 = 0;
    int acc4 = 0;
    logic last_in_hs = 1'b0;
    logic out_hs4 = 1'b0;
    logic rand_ready = 1'b0;
    logic hold_valid = 1'b0;
    logic [21:0] hold_val = '0;
    logic [37:0] exp_q[$];
    logic [21:0] obs_log[$];
    int obs_cyc[$];

    // Reference: walk positions 1..21, give non-powers-of-two the next data
    // bit, then set each parity so its covered positions XOR to zero.
    function automatic logic [20:0] ref_encode(input logic [15:0] d);
        logic [20:0] cw;
        logic par;
        int j;
        cw = '0;
        j = 0;
        for (int p = 1; p <= 21; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            par = 1'b0;
            for (int p = 1; p <= 21; p++) begin
                if (((p >> k) & 1) == 1) par ^= cw[p-1];
            end
            cw[(1 << k) - 1] = par;
        end
        return cw;
    endfunction

    // Syndrome = XOR of positions of set bits; a nonzero syndrome names the
    // flipped position.
    function automatic logic [16:0] ref_decode(input logic [20:0] cw_in);
        logic [20:0] cw;
        logic [15:0] d;
        int syn;
        int j;
        cw = cw_in;
        syn = 0;
        for (int i = 0; i < 21; i++) if (cw[i]) syn ^= (i + 1);
        if (syn >= 1 && syn <= 21) cw[syn-1] = ~cw[syn-1];
        d = '0;
        j = 0;
        for (int p = 1; p <= 21; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[j] = cw[p-1];
                j++;
            end
        end
        return {(syn != 0), d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        n_cmp++;
        n_err++;
        $error("FAIL %s observed=timeout/underflow expected=event", tag);
    endtask

    // Runs at the falling edge: handshakes seen here complete on the next rise.
    task automatic mon();
        logic [37:0] e;
        logic [20:0] code;
        logic [16:0] dec;
        logic inj;
        last_in_hs = 1'b0;
        out_hs4 = 1'b0;
        cyc++;
        if (!rst_n) begin
            hold_valid = 1'b0;
            return;
        end
        check("word_cnt", {16'h0, word_cnt}, 32'(exp_cnt % 65536));
        if (hold_valid) begin
            check("hold_valid", {31'h0, bus.out_valid}, 32'h1);
            check("hold_payload", {10'h0, bus.out_inj, bus.out_code}, {10'h0, hold_val});
        end
        if (bus.out_valid && bus.out_ready) begin
            obs_log.push_back({bus.out_inj, bus.out_code});
            obs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                fail_now("sb_unexpected_output");
            end else begin
                e = exp_q.pop_front();
                check("sb_code", {11'h0, bus.out_code}, {11'h0, e[20:0]});
                check("sb_inj", {31'h0, bus.out_inj}, {31'h0, e[21]});
                dec = ref_decode(bus.out_code);
                check("dec_data", {16'h0, dec[15:0]}, {16'h0, e[37:22]});
                check("dec_flag", {31'h0, dec[16]}, {31'h0, bus.out_inj});
            end
            exp_cnt++;
        end
        hold_valid = bus.out_valid && !bus.out_ready;
        hold_val = {bus.out_inj, bus.out_code};
        if (bus.in_valid && bus.in_ready) begin
            code = ref_encode(bus.in_data);
            inj = bus.inj_en && (bus.inj_pos <= 5'd20);
            if (inj) code[bus.inj_pos] = ~code[bus.inj_pos];
            exp_q.push_back({bus.in_data, inj, code});
            last_in_hs = 1'b1;
        end
        if (bus4.out_valid && bus4.out_ready) out_hs4 = 1'b1;
        if (bus4.in_valid && bus4.in_ready) acc4++;
    endtask

    task automatic step();
        if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        if (out_hs4) begin
            h4++;
            check("wrap_cnt", {28'h0, word_cnt4}, 32'(h4 % 16));
        end
    endtask

    task automatic send(input logic [15:0] d, input logic en, input logic [4:0] pos);
        bus.in_valid = 1'b1;
        bus.in_data = d;
        bus.inj_en = en;
        bus.inj_pos = pos;
        for (int t = 0; t < 64; t++) begin
            step();
            if (last_in_hs) return;
        end
        fail_now("send_timeout");
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        for (int t = 0; t < 64; t++) begin
            if (exp_q.size() == 0) return;
            step();
        end
        fail_now("drain_timeout");
    endtask

    initial begin
        int base;
        logic [15:0] w [5];
        logic [15:0] rd;

        bus.in_valid = 1'b0;  bus.in_data = '0;  bus.inj_en = 1'b0;
        bus.inj_pos = '0;     bus.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.inj_en = 1'b0;
        bus4.inj_pos = '0;    bus4.out_ready = 1'b0;

        // Reset values
        @(posedge clk); #1;
        step();
        step();
        check("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rst_out_code", {11'h0, bus.out_code}, 32'h0);
        check("rst_out_inj", {31'h0, bus.out_inj}, 32'h0);
        check("rst_word_cnt", {16'h0, word_cnt}, 32'h0);
        check("rst_word_cnt4", {28'h0, word_cnt4}, 32'h0);
        rst_n = 1'b1;

        // Directed stream with out_ready high
        bus.out_ready = 1'b1;
        base = obs_log.size();
        send(16'h0000, 1'b0, 5'd0);
        send(16'h0001, 1'b0, 5'd0);
        send(16'h8000, 1'b0, 5'd0);
        send(16'hFFFF, 1'b0, 5'd0);
        drain();
        check("stream_n", 32'(obs_log.size() - base), 32'd4);
        if (obs_log.size() - base == 4) begin
            check("stream_0", {10'h0, obs_log[base]},   32'h000000);
            check("stream_1", {10'h0, obs_log[base+1]}, 32'h000007);
            check("stream_2", {10'h0, obs_log[base+2]}, 32'h108009);
            check("stream_3", {10'h0, obs_log[base+3]}, 32'h1FFFFE);
            check("stream_back_to_back", 32'(obs_cyc[base+3] - obs_cyc[base]), 32'd3);
        end
        check("stream_word_cnt", {16'h0, word_cnt}, 32'd4);

        // Injection: valid position flips, out-of-range position does not
        base = obs_log.size();
        send(16'h0001, 1'b1, 5'd5);
        send(16'h0001, 1'b1, 5'd25);
        drain();
        check("inj_n", 32'(obs_log.size() - base), 32'd2);
        if (obs_log.size() - base == 2) begin
            check("inj_pos5", {10'h0, obs_log[base]},   32'h200027);
            check("inj_pos25", {10'h0, obs_log[base+1]}, 32'h000007);
        end

        // Backpressure: out_ready low for 3 cycles while streaming 5 words
        for (int i = 0; i < 5; i++) w[i] = 16'($urandom);
        base = obs_log.size();
        bus.out_ready = 1'b0;
        send(w[0], 1'b0, 5'd0);
        send(w[1], 1'b0, 5'd0);
        check("bp_in_ready_low", {31'h0, bus.in_ready}, 32'h0);
        check("bp_out_valid", {31'h0, bus.out_valid}, 32'h1);
        bus.in_valid = 1'b1;
        bus.in_data = w[2];
        step();
        check("bp_no_accept", {31'h0, last_in_hs}, 32'h0);
        bus.out_ready = 1'b1;
        for (int i = 2; i < 5; i++) send(w[i], 1'b0, 5'd0);
        drain();
        check("bp_n", 32'(obs_log.size() - base), 32'd5);
        if (obs_log.size() - base == 5) begin
            for (int i = 0; i < 5; i++) begin
                check("bp_order", {10'h0, obs_log[base+i]}, {11'h0, ref_encode(w[i])});
            end
        end

        // Random round-trip with random injection and random out_ready
        rand_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            rd = 16'($urandom);
            send(rd, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 24)));
            if ($urandom_range(0, 7) == 0) begin
                bus.in_valid = 1'b0;
                step();
            end
        end
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        // Reset with both stages full
        bus.out_ready = 1'b0;
        send(16'h1234, 1'b0, 5'd0);
        send(16'h5678, 1'b0, 5'd0);
        check("mid_full_in_ready", {31'h0, bus.in_ready}, 32'h0);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        check("mid_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("mid_word_cnt", {16'h0, word_cnt}, 32'h0);
        check("mid_in_ready", {31'h0, bus.in_ready}, 32'h1);
        rst_n = 1'b1;
        exp_q.delete();
        exp_cnt = 0;
        hold_valid = 1'b0;
        bus.out_ready = 1'b1;
        base = obs_log.size();
        send(16'hFFFF, 1'b0, 5'd0);
        drain();
        check("mid_after_n", 32'(obs_log.size() - base), 32'd1);
        if (obs_log.size() - base == 1) begin
            check("mid_after_code", {10'h0, obs_log[base]}, 32'h1FFFFE);
        end
        for (int t = 0; t < 4; t++) step();
        check("mid_stale_none", 32'(obs_log.size() - base), 32'd1);

        // Counter wrap on the 4-bit instance
        bus4.out_ready = 1'b1;
        bus4.in_valid = 1'b1;
        for (int t = 0; t < 80 && h4 < 17; t++) begin
            bus4.in_data = 16'($urandom);
            step();
            if (acc4 >= 17) bus4.in_valid = 1'b0;
        end
        check("wrap_total", 32'(h4), 32'd17);
        check("wrap_final", {28'h0, word_cnt4}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
